// File: rtl/mc_mem_unit.sv
// mc_mem_unit -- unified instruction/data memory stage for the multi-cycle MIPS core.
//
// Accepts a MemRead/MemWrite request in IDLE, holds it for LATENCY cycles, then
// performs the word access and loads IR/MDR. The control FSM holds its
// FETCH / LW_2 / SW_2 states until mem_ready pulses.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   mem_read, mem_write  access request (write wins if both are high)
//   iord                 address select: 0 = pc, 1 = alu_out
//   ir_write             load IR with the read data
//   pc, alu_out          byte addresses; word index = addr[ADDR_W+1:2]
//   write_data           store data
//   ir, mdr              instruction register, memory data register
//   mem_ready            one-cycle pulse when the access has completed
//   busy                 access in progress
//   err                  sticky error flag (misaligned access, or read+write together)
//
// Build option: MC_MEM_ALIGN_CHECK_EN -- when defined, an access with
// addr[1:0] != 0 is suppressed and sets err; otherwise addr[1:0] is ignored.
module mc_mem_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic              ir_write,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic [31:0]         addr;
  logic                req, misalign, access;

  // request captured at accept; inputs are ignored until the next IDLE
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wd_q;
  logic                wr_q, irw_q, mis_q;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  assign addr = iord ? alu_out : pc;
  assign req  = mem_read | mem_write;

`ifdef MC_MEM_ALIGN_CHECK_EN
  assign misalign = (addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // upper address bits wrap; byte-offset bits only matter for the alignment check
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // the access edge is the last BUSY edge
  assign access    = (state == BUSY) && (cnt == 4'd0);
  assign mem_ready = (state == DONE);
  assign busy      = (state == BUSY);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ir    <= '0;
      mdr   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        cnt <= 4'(LATENCY - 1);
        if (misalign || (mem_read && mem_write)) err <= 1'b1;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !wr_q && !mis_q) begin
        mdr <= mem[idx_q];
        if (irw_q) ir <= mem[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q <= addr[ADDR_W+1:2];
      wd_q  <= write_data;
      wr_q  <= mem_write;
      irw_q <= ir_write;
      mis_q <= misalign;
    end
  end

  // no reset on the array; a reset on the access edge still drops the write
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q && !mis_q) mem[idx_q] <= wd_q;
  end

endmodule

// File: tb/tb_mc_mem_unit.sv
// Bench for mc_mem_unit: two instances (LATENCY=2 and LATENCY=1) share one
// stimulus stream; a cycle-indexed behavioural model per instance is compared
// on every falling edge, and directed sequences pin literal expectations.
module tb_mc_mem_unit;

`ifdef MC_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, iord = 1'b0, ir_write = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, write_data = '0;

  logic [31:0] ir_d [2];
  logic [31:0] mdr_d [2];
  logic        rdy_d [2];
  logic        busy_d [2];
  logic        err_d [2];

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mc_mem_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .ir(ir_d[0]), .mdr(mdr_d[0]), .mem_ready(rdy_d[0]), .busy(busy_d[0]), .err(err_d[0]));

  mc_mem_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .ir(ir_d[1]), .mdr(mdr_d[1]), .mem_ready(rdy_d[1]), .busy(busy_d[1]), .err(err_d[1]));

  // ---------------- behavioural model ----------------
  // Each accepted request is scheduled to complete LAT cycles later; the unit
  // can accept again two cycles after completion.
  int          lat_m [2] = '{2, 1};
  logic [31:0] mem_m [2][DEPTH];
  int          cyc = 0;
  int          done_at [2] = '{0, 0};
  int          free_at [2] = '{0, 0};
  bit          pend [2];
  int          idx_l [2];
  logic [31:0] wd_l [2];
  bit          wr_l [2], irw_l [2], mis_l [2];
  logic [31:0] ir_e [2] = '{32'h0, 32'h0};
  logic [31:0] mdr_e [2] = '{32'h0, 32'h0};
  bit          rdy_e [2], busy_e [2], err_e [2];
  logic [31:0] ma;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 0; free_at[k] = cyc + 1;
        rdy_e[k] = 0; busy_e[k] = 0; err_e[k] = 0;
        ir_e[k] = 32'h0; mdr_e[k] = 32'h0;
      end else begin
        rdy_e[k] = 0;
        if (pend[k]) begin
          if (cyc == done_at[k]) begin
            if (!mis_l[k]) begin
              if (wr_l[k]) mem_m[k][idx_l[k]] = wd_l[k];
              else begin
                mdr_e[k] = mem_m[k][idx_l[k]];
                if (irw_l[k]) ir_e[k] = mem_m[k][idx_l[k]];
              end
            end
            pend[k] = 0; rdy_e[k] = 1; free_at[k] = cyc + 2;
          end
        end else if (cyc >= free_at[k] && (mem_read || mem_write)) begin
          ma = iord ? alu_out : pc;
          idx_l[k] = int'((ma / 4) % DEPTH);
          mis_l[k] = ALIGN && (ma % 4 != 0);
          wr_l[k]  = mem_write;
          irw_l[k] = ir_write;
          wd_l[k]  = write_data;
          if (mis_l[k] || (mem_read && mem_write)) err_e[k] = 1;
          pend[k] = 1; done_at[k] = cyc + lat_m[k];
        end
        busy_e[k] = pend[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.mem_ready", k), 32'(rdy_d[k]), 32'(rdy_e[k]));
        chk($sformatf("u%0d.busy", k), 32'(busy_d[k]), 32'(busy_e[k]));
        chk($sformatf("u%0d.err", k), 32'(err_d[k]), 32'(err_e[k]));
        chk($sformatf("u%0d.ir", k), ir_d[k], ir_e[k]);
        chk($sformatf("u%0d.mdr", k), mdr_d[k], mdr_e[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge with both units idle; wait for u0 (slower) to finish.
  task automatic wait_ready0();
    int n = 0;
    while (!rdy_d[0] && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!rdy_d[0]) begin
      fails++;
      $display("FAIL wait_ready0: mem_ready not seen within %0d cycles", n);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input bit io, input bit irw,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; iord = io; ir_write = irw;
    pc = p; alu_out = a; write_data = d;
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    wait_ready0();
    @(negedge clk);
  endtask

  int pulses;

  initial begin
    // reset
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk("reset.ir", ir_d[0], 32'h0);
    chk("reset.mdr", mdr_d[0], 32'h0);
    chk("reset.busy", 32'(busy_d[0]), 32'h0);
    chk("reset.ready", 32'(rdy_d[0]), 32'h0);
    chk("reset.err", 32'(err_d[0]), 32'h0);
    chk_en = 1;

    // fetch with LATENCY=2: mem[4] = 0x2008000A, read via pc=0x10
    access(0, 1, 1, 0, 32'h0, 32'h10, 32'h2008000A);
    mem_read = 1; iord = 0; pc = 32'h10; ir_write = 1;
    @(negedge clk);                       // after E0
    mem_read = 0;
    chk("fetch.E0.busy", 32'(busy_d[0]), 32'h1);
    chk("fetch.E0.ready", 32'(rdy_d[0]), 32'h0);
    @(negedge clk);                       // after E1
    chk("fetch.E1.busy", 32'(busy_d[0]), 32'h1);
    chk("fetch.E1.ready", 32'(rdy_d[0]), 32'h0);
    @(negedge clk);                       // after E2
    chk("fetch.E2.ready", 32'(rdy_d[0]), 32'h1);
    chk("fetch.E2.busy", 32'(busy_d[0]), 32'h0);
    chk("fetch.E2.ir", ir_d[0], 32'h2008000A);
    chk("fetch.E2.mdr", mdr_d[0], 32'h2008000A);
    chk("fetch.lat1.ir", ir_d[1], 32'h2008000A);
    @(negedge clk);                       // after E3
    chk("fetch.E3.ready", 32'(rdy_d[0]), 32'h0);
    chk("fetch.E3.busy", 32'(busy_d[0]), 32'h0);

    // store then load without ir_write
    access(0, 1, 1, 0, 32'h0, 32'h20, 32'hDEADBEEF);
    access(1, 0, 1, 0, 32'h0, 32'h20, 32'h0);
    chk("load.mdr", mdr_d[0], 32'hDEADBEEF);
    chk("load.ir_held", ir_d[0], 32'h2008000A);

    // inputs changing while busy are ignored
    mem_read = 1; iord = 0; pc = 32'h10; ir_write = 1;
    @(negedge clk);                       // after E0
    mem_read = 1; iord = 1; pc = 32'h20; alu_out = 32'h24; write_data = 32'h5555AAAA;
    @(negedge clk);                       // after E1
    mem_read = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy_d[0]) pulses++;
      @(negedge clk);
    end
    chk("busy_ignore.pulses", 32'(pulses), 32'h1);
    chk("busy_ignore.mdr", mdr_d[0], 32'h2008000A);

    // misaligned read of 0x22
    access(1, 0, 1, 0, 32'h0, 32'h22, 32'h0);
    chk("misalign.mdr", mdr_d[0], ALIGN ? 32'h2008000A : 32'hDEADBEEF);
    chk("misalign.err", 32'(err_d[0]), 32'(ALIGN));
    access(1, 0, 1, 0, 32'h0, 32'h20, 32'h0);
    chk("misalign.err_sticky", 32'(err_d[0]), 32'(ALIGN));

    // reset aborts an in-flight write
    access(0, 1, 1, 0, 32'h0, 32'h30, 32'h11111111);
    mem_write = 1; iord = 1; alu_out = 32'h30; write_data = 32'h22222222;
    @(negedge clk);                       // after accept
    mem_write = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (rdy_d[0]) pulses++;
      @(negedge clk);
    end
    chk("abort.pulses", 32'(pulses), 32'h0);
    chk("abort.err_cleared", 32'(err_d[0]), 32'h0);
    access(1, 0, 1, 0, 32'h0, 32'h30, 32'h0);
    chk("abort.mem_kept", mdr_d[0], 32'h11111111);
    chk("abort.mem_kept_lat1", mdr_d[1], 32'h11111111);

    // LATENCY=1 with read held high; alu_out=0x400 wraps to index 0
    access(0, 1, 1, 0, 32'h0, 32'h0, 32'hCAFE0000);
    mem_read = 1; iord = 1; alu_out = 32'h400; ir_write = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("held.ready[%0d]", i), 32'(rdy_d[1]), (i % 3 == 1) ? 32'h1 : 32'h0);
      if (i == 1) chk("held.wrap_mdr", mdr_d[1], 32'hCAFE0000);
    end
    mem_read = 0;
    repeat (8) @(negedge clk);

    // fill memory so every later read is defined
    for (int i = 0; i < DEPTH; i++)
      access(0, 1, 1, 0, 32'h0, 32'(i * 4), $urandom);

    // random traffic, including requests while busy and occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      mem_read   = ($urandom_range(0, 2) == 0);
      mem_write  = ($urandom_range(0, 3) == 0);
      iord       = $urandom_range(0, 1) != 0;
      ir_write   = $urandom_range(0, 1) != 0;
      pc         = $urandom;
      alu_out    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      write_data = $urandom;
      @(negedge clk);
    end
    rst = 0; mem_read = 0; mem_write = 0;
    repeat (6) @(negedge clk);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
